// File: rtl/vanilla_exe_bubble_classifier.sv
// Profiling shadow of the vanilla front end: tags every bubble entering EXE with a
// cause code and the word PC it is blamed on. Purely observational; never feeds the core.
module vanilla_exe_bubble_classifier #(
  parameter int pc_width_p   = 10,
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [pc_width_p-1:0]   pc_r,
  input  logic [data_width_p-1:0] id_pc,
  input  logic [data_width_p-1:0] exe_pc,
  input  logic                    flush,
  input  logic                    branch_mispredict,
  input  logic                    jalr_mispredict,
  input  logic                    icache_miss,
  input  logic                    icache_miss_in_pipe,
  input  logic                    stall_all,
  input  logic                    stall_id,
  input  logic                    stall_depend_long_op,
  input  logic                    stall_depend_local_load,
  input  logic                    stall_depend_imul,
  input  logic                    stall_bypass,
  input  logic                    stall_lr_aq,
  input  logic                    stall_fence,
  input  logic                    stall_amo_aq,
  input  logic                    stall_amo_rl,
  input  logic                    stall_fdiv_busy,
  input  logic                    stall_idiv_busy,
  input  logic                    stall_fcsr,
  input  logic                    stall_remote_req,
  input  logic                    stall_remote_credit,
  input  logic                    stall_barrier,
  output logic [4:0]              exe_bubble_type_o,
  output logic [pc_width_p-1:0]   exe_bubble_pc_o
);

  typedef enum logic [4:0] {
    e_exe_no_bubble         = 5'd0,
    e_exe_branch_miss       = 5'd1,
    e_exe_jalr_miss         = 5'd2,
    e_exe_icache_miss       = 5'd3,
    e_exe_depend_long_op    = 5'd4,
    e_exe_depend_local_load = 5'd5,
    e_exe_depend_imul       = 5'd6,
    e_exe_bypass            = 5'd7,
    e_exe_lr_aq             = 5'd8,
    e_exe_fence             = 5'd9,
    e_exe_amo_aq            = 5'd10,
    e_exe_amo_rl            = 5'd11,
    e_exe_fdiv_busy         = 5'd12,
    e_exe_idiv_busy         = 5'd13,
    e_exe_fcsr              = 5'd14,
    e_exe_remote_req        = 5'd15,
    e_exe_remote_credit     = 5'd16,
    e_exe_barrier           = 5'd17,
    e_exe_unknown           = 5'd18
  } exe_bubble_type_e;

  exe_bubble_type_e id_type_r, id_type_n, exe_type_r, exe_type_n;
  exe_bubble_type_e flush_type, stall_type;
  logic [pc_width_p-1:0] id_pc_r, id_pc_n, exe_pc_r, exe_pc_n;
  logic [pc_width_p-1:0] exe_wpc, id_wpc;
  logic                  unused_pc_bits;

  // Byte PCs become word PCs by dropping the byte offset and the bits above the icache tag.
  assign exe_wpc        = exe_pc[pc_width_p+1:2];
  assign id_wpc         = id_pc[pc_width_p+1:2];
  assign unused_pc_bits = ^{exe_pc, id_pc};

  always_comb begin
    if (branch_mispredict)    flush_type = e_exe_branch_miss;
    else if (jalr_mispredict) flush_type = e_exe_jalr_miss;
    else                      flush_type = e_exe_unknown;
  end

  // Earlier causes win; a stall with no recognised cause must still be reported as a bubble.
  always_comb begin
    if      (stall_depend_long_op)    stall_type = e_exe_depend_long_op;
    else if (stall_depend_local_load) stall_type = e_exe_depend_local_load;
    else if (stall_depend_imul)       stall_type = e_exe_depend_imul;
    else if (stall_bypass)            stall_type = e_exe_bypass;
    else if (stall_lr_aq)             stall_type = e_exe_lr_aq;
    else if (stall_fence)             stall_type = e_exe_fence;
    else if (stall_amo_aq)            stall_type = e_exe_amo_aq;
    else if (stall_amo_rl)            stall_type = e_exe_amo_rl;
    else if (stall_fdiv_busy)         stall_type = e_exe_fdiv_busy;
    else if (stall_idiv_busy)         stall_type = e_exe_idiv_busy;
    else if (stall_fcsr)              stall_type = e_exe_fcsr;
    else if (stall_remote_req)        stall_type = e_exe_remote_req;
    else if (stall_remote_credit)     stall_type = e_exe_remote_credit;
    else if (stall_barrier)           stall_type = e_exe_barrier;
    else                              stall_type = e_exe_unknown;
  end

  always_comb begin
    // NOTE: every output gets a hold default first so no path can infer a latch.
    id_type_n  = id_type_r;
    id_pc_n    = id_pc_r;
    exe_type_n = exe_type_r;
    exe_pc_n   = exe_pc_r;

    if (!stall_all) begin
      if (flush) begin
        exe_type_n = flush_type;
        exe_pc_n   = exe_wpc;
      end else if (stall_id) begin
        exe_type_n = stall_type;
        exe_pc_n   = id_wpc;
      end else begin
        exe_type_n = id_type_r;
        exe_pc_n   = id_pc_r;
      end

      // A held ID slot keeps its bubble; an empty one always carries pc 0.
      if (flush) begin
        id_type_n = flush_type;
        id_pc_n   = exe_wpc;
      end else if (!stall_id) begin
        if (icache_miss || icache_miss_in_pipe) begin
          id_type_n = e_exe_icache_miss;
          id_pc_n   = pc_r;
        end else begin
          id_type_n = e_exe_no_bubble;
          id_pc_n   = '0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every slot samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      id_type_r  <= e_exe_no_bubble;
      id_pc_r    <= '0;
      exe_type_r <= e_exe_no_bubble;
      exe_pc_r   <= '0;
    end else begin
      id_type_r  <= id_type_n;
      id_pc_r    <= id_pc_n;
      exe_type_r <= exe_type_n;
      exe_pc_r   <= exe_pc_n;
    end
  end

  assign exe_bubble_type_o = exe_type_r;
  assign exe_bubble_pc_o   = exe_pc_r;

endmodule

// File: tb/tb_vanilla_exe_bubble_classifier.sv
// Scenario bench for the EXE bubble classifier: expected tags are queued as stimulus
// is applied and popped for comparison one cycle later.
module tb_vanilla_exe_bubble_classifier;
  localparam int PCW = 10;
  localparam int DW  = 32;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [PCW-1:0] pc_r;
  logic [DW-1:0]  id_pc, exe_pc;
  logic           flush, branch_mispredict, jalr_mispredict, icache_miss, icache_miss_in_pipe;
  logic           stall_all, stall_id;
  logic [13:0]    causes;
  logic [4:0]     exe_bubble_type_o;
  logic [PCW-1:0] exe_bubble_pc_o;

  typedef struct {
    logic           flush, bm, jm, icm, icmp, sall, sid;
    logic [13:0]    causes;
    logic [PCW-1:0] pc_r;
    logic [DW-1:0]  id_pc, exe_pc;
  } stim_t;

  typedef struct {
    logic [4:0]     typ;
    logic [PCW-1:0] pc;
    string          name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  vanilla_exe_bubble_classifier #(.pc_width_p(PCW), .data_width_p(DW)) dut (
    .clk_i                   (clk_i),
    .reset_i                 (reset_i),
    .pc_r                    (pc_r),
    .id_pc                   (id_pc),
    .exe_pc                  (exe_pc),
    .flush                   (flush),
    .branch_mispredict       (branch_mispredict),
    .jalr_mispredict         (jalr_mispredict),
    .icache_miss             (icache_miss),
    .icache_miss_in_pipe     (icache_miss_in_pipe),
    .stall_all               (stall_all),
    .stall_id                (stall_id),
    .stall_depend_long_op    (causes[0]),
    .stall_depend_local_load (causes[1]),
    .stall_depend_imul       (causes[2]),
    .stall_bypass            (causes[3]),
    .stall_lr_aq             (causes[4]),
    .stall_fence             (causes[5]),
    .stall_amo_aq            (causes[6]),
    .stall_amo_rl            (causes[7]),
    .stall_fdiv_busy         (causes[8]),
    .stall_idiv_busy         (causes[9]),
    .stall_fcsr              (causes[10]),
    .stall_remote_req        (causes[11]),
    .stall_remote_credit     (causes[12]),
    .stall_barrier           (causes[13]),
    .exe_bubble_type_o       (exe_bubble_type_o),
    .exe_bubble_pc_o         (exe_bubble_pc_o)
  );

  function automatic stim_t idle();
    stim_t s;
    s.flush = 0; s.bm = 0; s.jm = 0; s.icm = 0; s.icmp = 0; s.sall = 0; s.sid = 0;
    s.causes = '0; s.pc_r = '0; s.id_pc = '0; s.exe_pc = '0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    flush = s.flush; branch_mispredict = s.bm; jalr_mispredict = s.jm;
    icache_miss = s.icm; icache_miss_in_pipe = s.icmp;
    stall_all = s.sall; stall_id = s.sid; causes = s.causes;
    pc_r = s.pc_r; id_pc = s.id_pc; exe_pc = s.exe_pc;
  endtask

  function automatic exp_t mk(input logic [4:0] t, input logic [PCW-1:0] p, input string n);
    exp_t e;
    e.typ = t; e.pc = p; e.name = n;
    return e;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(idle());
    reset_i = 1'b1;
    #1 reset_i = 1'b0;
    #1;
    sb.push_back(mk(5'd0, '0, "reset_state"));
    e = sb.pop_front(); n_checks++;
    if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
      n_errors++;
      $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
               e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
    end
    step(); step();
    reset_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(5'd0, '0, "idle_after_reset"));
      step();
      e = sb.pop_front(); n_checks++;
      if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
        n_errors++;
        $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
                 e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
      end
    end
  endtask

  task automatic test_branch_flush();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  e;
    st[0] = idle(); st[0].flush = 1; st[0].bm = 1; st[0].exe_pc = 32'h100;
    st[1] = idle(); st[2] = idle();
    ex[0] = mk(5'd1, 10'h40, "branch_bubble_1");
    ex[1] = mk(5'd1, 10'h40, "branch_bubble_2");
    ex[2] = mk(5'd0, 10'h0,  "branch_done");
    for (int i = 0; i < 3; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      e = sb.pop_front(); n_checks++;
      if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
        n_errors++;
        $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
                 e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
      end
    end
  endtask

  task automatic test_stall_id();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st[0] = idle(); st[0].icm = 1; st[0].pc_r = 10'h55;
    st[1] = idle(); st[1].sid = 1; st[1].causes[5] = 1; st[1].causes[3] = 1; st[1].id_pc = 32'h208;
    st[2] = idle(); st[3] = idle();
    ex[0] = mk(5'd0, 10'h0,  "miss_enters_id");
    ex[1] = mk(5'd7, 10'h82, "bypass_beats_fence");
    ex[2] = mk(5'd3, 10'h55, "id_held_across_stall");
    ex[3] = mk(5'd0, 10'h0,  "stall_done");
    for (int i = 0; i < 4; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      e = sb.pop_front(); n_checks++;
      if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
        n_errors++;
        $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
                 e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
      end
    end
  endtask

  task automatic test_icache_stall_all();
    stim_t st[9];
    exp_t  ex[9];
    exp_t  e;
    st[0] = idle(); st[0].icm = 1; st[0].pc_r = 10'h55;
    st[1] = idle();
    for (int i = 2; i < 5; i++) begin
      st[i] = idle(); st[i].sall = 1; st[i].flush = 1; st[i].bm = 1; st[i].icm = 1;
      st[i].sid = 1; st[i].causes = 14'h3FFF; st[i].pc_r = 10'h3FF;
      st[i].id_pc = $urandom; st[i].exe_pc = $urandom;
    end
    st[5] = idle();
    st[6] = idle(); st[6].icmp = 1; st[6].pc_r = 10'h2A;
    st[7] = idle(); st[8] = idle();
    ex[0] = mk(5'd0, 10'h0,  "miss_in_id");
    ex[1] = mk(5'd3, 10'h55, "miss_in_exe");
    ex[2] = mk(5'd3, 10'h55, "stall_all_hold_1");
    ex[3] = mk(5'd3, 10'h55, "stall_all_hold_2");
    ex[4] = mk(5'd3, 10'h55, "stall_all_hold_3");
    ex[5] = mk(5'd0, 10'h0,  "after_stall_all");
    ex[6] = mk(5'd0, 10'h0,  "pipe_miss_in_id");
    ex[7] = mk(5'd3, 10'h2A, "pipe_miss_in_exe");
    ex[8] = mk(5'd0, 10'h0,  "pipe_miss_done");
    for (int i = 0; i < 9; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      e = sb.pop_front(); n_checks++;
      if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
        n_errors++;
        $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
                 e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
      end
    end
  endtask

  task automatic test_jalr_unknown();
    stim_t st[9];
    exp_t  ex[9];
    exp_t  e;
    st[0] = idle(); st[0].flush = 1; st[0].jm = 1; st[0].sid = 1; st[0].causes[13] = 1;
    st[0].exe_pc = 32'h3FC; st[0].id_pc = 32'h44;
    st[1] = idle();
    st[2] = idle(); st[2].sid = 1; st[2].id_pc = 32'h40;
    st[3] = idle();
    st[4] = idle(); st[4].flush = 1; st[4].exe_pc = 32'h80;
    st[5] = idle();
    st[6] = idle(); st[6].flush = 1; st[6].bm = 1; st[6].jm = 1; st[6].exe_pc = 32'hC;
    st[7] = idle(); st[8] = idle();
    ex[0] = mk(5'd2,  10'hFF, "jalr_beats_stall");
    ex[1] = mk(5'd2,  10'hFF, "jalr_bubble_2");
    ex[2] = mk(5'd18, 10'h10, "stall_no_cause");
    ex[3] = mk(5'd0,  10'h0,  "after_unknown_stall");
    ex[4] = mk(5'd18, 10'h20, "flush_no_cause_1");
    ex[5] = mk(5'd18, 10'h20, "flush_no_cause_2");
    ex[6] = mk(5'd1,  10'h3,  "branch_beats_jalr_1");
    ex[7] = mk(5'd1,  10'h3,  "branch_beats_jalr_2");
    ex[8] = mk(5'd0,  10'h0,  "flushes_done");
    for (int i = 0; i < 9; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      e = sb.pop_front(); n_checks++;
      if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
        n_errors++;
        $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
                 e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
      end
    end
  endtask

  // Each cause is asserted together with every lower-priority cause; the lowest index must win.
  task automatic test_stall_priority();
    stim_t       s;
    exp_t        e;
    logic [13:0] ones;
    ones = 14'h3FFF;
    for (int i = 0; i < 14; i++) begin
      s = idle(); s.sid = 1; s.causes = ones << i; s.id_pc = 32'h400 + 32'(4 * i);
      drive(s);
      sb.push_back(mk(5'(4 + i), 10'(10'h100 + i), $sformatf("stall_cause_%0d", i)));
      step();
      e = sb.pop_front(); n_checks++;
      if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
        n_errors++;
        $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
                 e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s;
    exp_t  e;
    s = idle(); s.icm = 1; s.pc_r = 10'h77;
    drive(s); sb.push_back(mk(5'd0, 10'h0, "miss_before_stall")); step();
    e = sb.pop_front(); n_checks++;
    if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
      n_errors++;
      $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
               e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
    end
    s = idle(); s.sid = 1; s.causes[2] = 1; s.id_pc = 32'h10;
    drive(s); sb.push_back(mk(5'd6, 10'h4, "imul_stall")); step();
    e = sb.pop_front(); n_checks++;
    if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
      n_errors++;
      $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
               e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
    end
    reset_i = 1'b0;
    sb.push_back(mk(5'd0, 10'h0, "async_reset_mid_stall"));
    #1;
    e = sb.pop_front(); n_checks++;
    if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
      n_errors++;
      $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
               e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
    end
    #1 reset_i = 1'b1;
    drive(idle()); sb.push_back(mk(5'd0, 10'h0, "id_cleared_by_reset")); step();
    e = sb.pop_front(); n_checks++;
    if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
      n_errors++;
      $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
               e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
    end
  endtask

  task automatic test_reset_after_flush();
    stim_t s;
    exp_t  e;
    s = idle(); s.flush = 1; s.bm = 1; s.exe_pc = 32'h100;
    drive(s); sb.push_back(mk(5'd1, 10'h40, "flush_before_reset")); step();
    e = sb.pop_front(); n_checks++;
    if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
      n_errors++;
      $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
               e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
    end
    drive(idle());
    reset_i = 1'b0;
    sb.push_back(mk(5'd0, 10'h0, "async_reset_same_cycle"));
    #1;
    e = sb.pop_front(); n_checks++;
    if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
      n_errors++;
      $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
               e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
    end
    #1 reset_i = 1'b1;
    sb.push_back(mk(5'd0, 10'h0, "second_bubble_dropped")); step();
    e = sb.pop_front(); n_checks++;
    if (exe_bubble_type_o !== e.typ || exe_bubble_pc_o !== e.pc) begin
      n_errors++;
      $display("FAIL %s: got type=%0d pc=0x%0h, expected type=%0d pc=0x%0h",
               e.name, exe_bubble_type_o, exe_bubble_pc_o, e.typ, e.pc);
    end
  endtask

  initial begin
    test_reset();
    test_reset_after_flush();
    test_branch_flush();
    test_stall_id();
    test_icache_stall_all();
    test_jalr_unknown();
    test_stall_priority();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
